ex_stage: RTL and testbench
===========================

# ex_stage

Combined control-decode and execute stage for the 64-bit LEGv8 subset CPU. It sits between the register-file read (decode) stage and writeback/fetch. It decodes the 11-bit opcode, computes the ALU result, and performs data-memory loads and stores. It also resolves branches and registers the writeback and PC-redirect results for the next cycle.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  instr/pc/rs data valid this cycle
- instr  in  32  instruction word
- pc  in  64  address of instr
- rs1_data  in  64  register-file value at rs1_addr
- rs2_data  in  64  register-file value at rs2_addr
- rs1_addr  out  5  combinational: instr[9:5]
- rs2_addr  out  5  combinational: Reg2Loc ? instr[4:0] : instr[20:16]
- wb_en  out  1  registered: write wb_data to wb_reg
- wb_reg  out  5  registered destination, instr[4:0]
- wb_data  out  64  registered writeback value
- pc_src  out  1  registered: take branch_addr
- branch_addr  out  64  registered branch target
- illegal  out  1  registered: unrecognised opcode

## Operation
- Opcode decode uses op = instr[31:21]. It produces Reg2Loc, B, BZ, BNZ, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc[1:0] and RegWrite.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: R-type. ALUSrc=00, ALUOp=10, RegWrite.
  - ADDI 1001000100x, SUBI 1101000100x: ALUSrc=10, ALUOp=10, RegWrite.
  - LDUR 11111000010: ALUSrc=01, ALUOp=00, MemRead, MemtoReg, RegWrite.
  - STUR 11111000000: Reg2Loc=1, ALUSrc=01, ALUOp=00, MemWrite.
  - CBZ 10110100xxx: Reg2Loc=1, ALUOp=01, BZ. CBNZ 10110101xxx: Reg2Loc=1, ALUOp=01, BNZ.
  - B 000101xxxxx: B.
  - Any other opcode: all controls 0 and illegal=1.
- Operand B selection:
  - ALUSrc=00: rs2_data.
  - ALUSrc=01: sign-extended instr[20:12] (9-bit DT offset).
  - ALUSrc=10: zero-extended instr[21:10] (12-bit immediate).
- ALU operation:
  - ALUOp=00: add.
  - ALUOp=01: pass operand B (the CB test value).
  - ALUOp=10: function from op, one of add, sub, and, orr (the I-types use add or sub).
  - All arithmetic is 64-bit modulo 2^64; no flags.
- Branch target:
  - B: pc + (sext(instr[25:0]) << 2).
  - CBZ/CBNZ: pc + (sext(instr[23:5]) << 2).
  - Other instructions: pc + 4.
  - Computed modulo 2^64.
- pc_src = B | (BZ & rs2_data==0) | (BNZ & rs2_data!=0).
- Writeback:
  - wb_data = MemtoReg ? load data : ALU result.
  - wb_en = RegWrite & (instr[4:0] != 31); writes to XZR are suppressed.
- Data memory: 32 x 64-bit, indexed by ALU result[7:3]. Address bits [2:0] and bits above 7 are ignored.
- valid_in=0 acts as a bubble: no memory write, and wb_en, pc_src and illegal register as 0.

## Timing
- Decode, ALU, branch evaluation and memory read are combinational from the inputs. All outputs except rs1_addr/rs2_addr register at the rising edge, giving 1-cycle latency.
- STUR writes memory at the same edge that registers the results. A LDUR in the following cycle to the same address returns the new data.
- LDUR and STUR to the same address in one cycle cannot occur, since there is a single instruction per cycle.
- Reset (asynchronous, any time including mid-stream) clears wb_en, wb_reg, wb_data, pc_src, branch_addr and illegal to 0 immediately.
- Reset leaves data-memory contents unchanged. Memory is zero-initialised at time 0.
- The first valid result appears one edge after valid_in is sampled with rst low.

## Configuration
- EX_STAGE_DATA_MEM_EN
  - Defined: the internal 32-entry data memory is present as described above.
  - Undefined: no memory is instantiated. LDUR writes back 0 (wb_en still asserted for rd != 31), and STUR has no effect.
  - Decode and illegal flagging are identical in both builds.

## Test plan
- ADD X3,X1,X2 (instr 0x8B020023) with rs1=5, rs2=7 -> next edge wb_en=1, wb_reg=3, wb_data=12, pc_src=0; rs2_addr=2 combinationally.
- SUBI X0,X0,#1 with rs1=0 -> wb_data=0xFFFF_FFFF_FFFF_FFFF. ADD with rd=31 -> wb_en=0.
- STUR X2,[X1,#8] with rs1=0x10, rs2=0xABCD, then LDUR X4,[X1,#8] -> wb_reg=4, wb_data=0xABCD. Without the macro, wb_data=0.
- CBZ X5,#-2 at pc=0x100:
  - rs2=0 -> pc_src=1, branch_addr=0xF8.
  - rs2=1 -> pc_src=0.
  - CBNZ behaves inversely.
- B #+3 at pc=0x40 -> pc_src=1, branch_addr=0x4C, wb_en=0.
- Opcode 0x000 -> illegal=1, wb_en=0. Assert rst mid-stream -> all registered outputs 0 without waiting for a clock edge. valid_in=0 -> no memory write.

Source files
------------

// File: rtl/ex_stage.sv
// Decode + execute stage for the LEGv8 subset: ALU, branch resolution, data memory, registered writeback.
// The data memory is built only when EX_STAGE_DATA_MEM_EN is defined.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [31:0] instr,
   input  logic [63:0] pc,
   input  logic [63:0] rs1_data,
   input  logic [63:0] rs2_data,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output logic        wb_en,
   output logic [4:0]  wb_reg,
   output logic [63:0] wb_data,
   output logic        pc_src,
   output logic [63:0] branch_addr,
   output logic        illegal
);

   localparam int unsigned XLEN     = 64;
   localparam int unsigned MEM_AW   = 5;
   localparam int unsigned MEM_SIZE = 32;

   typedef enum logic [1:0] {FN_ADD, FN_SUB, FN_AND, FN_ORR} alu_fn_e;

   logic [10:0]     w_op;
   logic            w_reg2loc, w_b, w_bz, w_bnz, w_mem_read, w_mem_to_reg;
   logic            w_mem_write, w_reg_write, w_illegal;
   logic [1:0]      w_alu_op, w_alu_src;
   alu_fn_e         w_fn;
   logic [XLEN-1:0] w_opb, w_alu, w_load, w_wb_data, w_branch;
   logic            w_pc_src;
   logic [MEM_AW-1:0] w_mem_idx;

   assign w_op     = instr[31:21];
   assign rs1_addr = instr[9:5];
   assign rs2_addr = w_reg2loc ? instr[4:0] : instr[20:16];

   // Opcode decode into the classic single-cycle control signals
   always_comb begin
      w_reg2loc    = 1'b0;
      w_b          = 1'b0;
      w_bz         = 1'b0;
      w_bnz        = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_to_reg = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_op     = 2'b00;
      w_alu_src    = 2'b00;
      w_fn         = FN_ADD;
      w_illegal    = 1'b0;
      casez (w_op)
         11'b10001011000: begin w_alu_op = 2'b10; w_reg_write = 1'b1; w_fn = FN_ADD; end
         11'b11001011000: begin w_alu_op = 2'b10; w_reg_write = 1'b1; w_fn = FN_SUB; end
         11'b10001010000: begin w_alu_op = 2'b10; w_reg_write = 1'b1; w_fn = FN_AND; end
         11'b10101010000: begin w_alu_op = 2'b10; w_reg_write = 1'b1; w_fn = FN_ORR; end
         11'b1001000100?: begin
            w_alu_src = 2'b10; w_alu_op = 2'b10; w_reg_write = 1'b1; w_fn = FN_ADD;
         end
         11'b1101000100?: begin
            w_alu_src = 2'b10; w_alu_op = 2'b10; w_reg_write = 1'b1; w_fn = FN_SUB;
         end
         11'b11111000010: begin
            w_alu_src = 2'b01; w_mem_read = 1'b1; w_mem_to_reg = 1'b1; w_reg_write = 1'b1;
         end
         11'b11111000000: begin w_reg2loc = 1'b1; w_alu_src = 2'b01; w_mem_write = 1'b1; end
         11'b10110100???: begin w_reg2loc = 1'b1; w_alu_op = 2'b01; w_bz = 1'b1; end
         11'b10110101???: begin w_reg2loc = 1'b1; w_alu_op = 2'b01; w_bnz = 1'b1; end
         11'b000101?????: w_b = 1'b1;
         default:         w_illegal = 1'b1;
      endcase
   end

   // Operand B select and ALU
   always_comb begin
      case (w_alu_src)
         2'b01:   w_opb = {{55{instr[20]}}, instr[20:12]};
         2'b10:   w_opb = {52'd0, instr[21:10]};
         default: w_opb = rs2_data;
      endcase
      case (w_alu_op)
         2'b01: w_alu = w_opb;
         2'b10: begin
            case (w_fn)
               FN_SUB:  w_alu = rs1_data - w_opb;
               FN_AND:  w_alu = rs1_data & w_opb;
               FN_ORR:  w_alu = rs1_data | w_opb;
               default: w_alu = rs1_data + w_opb;
            endcase
         end
         default: w_alu = rs1_data + w_opb;
      endcase
   end

   // Branch target and decision
   always_comb begin
      if (w_b)
         w_branch = pc + {{36{instr[25]}}, instr[25:0], 2'b00};
      else if (w_bz || w_bnz)
         w_branch = pc + {{43{instr[23]}}, instr[23:5], 2'b00};
      else
         w_branch = pc + XLEN'(4);
      w_pc_src = w_b | (w_bz & (rs2_data == '0)) | (w_bnz & (rs2_data != '0));
   end

   assign w_mem_idx = w_alu[7:3];

`ifdef EX_STAGE_DATA_MEM_EN
   logic [XLEN-1:0] r_mem [MEM_SIZE];

   // Store lands at the same edge as the result registers, so a following load sees it
   always_ff @(posedge clk) begin
      if (valid_in && w_mem_write)
         r_mem[w_mem_idx] <= rs2_data;
   end

   assign w_load = r_mem[w_mem_idx];
`else
   logic w_unused_mem;
   assign w_unused_mem = w_mem_write ^ (^w_mem_idx);
   assign w_load       = '0;
`endif

   assign w_wb_data = (w_mem_to_reg && w_mem_read) ? w_load : w_alu;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en       <= 1'b0;
         wb_reg      <= '0;
         wb_data     <= '0;
         pc_src      <= 1'b0;
         branch_addr <= '0;
         illegal     <= 1'b0;
      end else begin
         wb_en       <= valid_in & w_reg_write & (instr[4:0] != 5'd31);
         wb_reg      <= instr[4:0];
         wb_data     <= w_wb_data;
         pc_src      <= valid_in & w_pc_src;
         branch_addr <= w_branch;
         illegal     <= valid_in & w_illegal;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized instructions against a spec-level model.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [31:0] instr;
   logic [63:0] pc, rs1_data, rs2_data;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        wb_en;
   logic [4:0]  wb_reg;
   logic [63:0] wb_data;
   logic        pc_src;
   logic [63:0] branch_addr;
   logic        illegal;

   int n_checks = 0;
   int n_errors = 0;

   ex_stage dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .instr(instr), .pc(pc),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .pc_src(pc_src),
      .branch_addr(branch_addr), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Reference state: memory image and the expectations for the instruction in flight
   logic [63:0] m_mem [32];
   logic [4:0]  e_rs2_addr, e_wb_reg, e_st_idx;
   logic        e_wb_en, e_pc_src, e_illegal, e_chk_data, e_store, e_valid;
   logic [63:0] e_wb_data, e_br, e_st_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [31:0] ins, input logic [63:0] p, a, b, input logic v);
      logic [10:0] op;
      logic [63:0] imm12, dt, addr, res;
      logic is_add, is_sub, is_and, is_orr, is_addi, is_subi, is_ld, is_st, is_cbz, is_cbnz, is_b;
      logic writes;
      op      = ins[31:21];
      imm12   = 64'(ins[21:10]);
      dt      = 64'($signed(ins[20:12]));
      addr    = a + dt;
      is_add  = (op == 11'h458);
      is_sub  = (op == 11'h658);
      is_and  = (op == 11'h450);
      is_orr  = (op == 11'h550);
      is_addi = (op[10:1] == 10'b1001000100);
      is_subi = (op[10:1] == 10'b1101000100);
      is_ld   = (op == 11'h7C2);
      is_st   = (op == 11'h7C0);
      is_cbz  = (op[10:3] == 8'hB4);
      is_cbnz = (op[10:3] == 8'hB5);
      is_b    = (op[10:5] == 6'b000101);
      writes  = is_add | is_sub | is_and | is_orr | is_addi | is_subi | is_ld;
      res = 64'd0;
      if (is_add)  res = a + b;
      if (is_sub)  res = a - b;
      if (is_and)  res = a & b;
      if (is_orr)  res = a | b;
      if (is_addi) res = a + imm12;
      if (is_subi) res = a - imm12;
`ifdef EX_STAGE_DATA_MEM_EN
      if (is_ld)   res = m_mem[addr[7:3]];
`else
      if (is_ld)   res = 64'd0;
`endif
      e_rs2_addr = (is_st | is_cbz | is_cbnz) ? ins[4:0] : ins[20:16];
      e_valid    = v;
      e_wb_en    = v && writes && (ins[4:0] != 5'd31);
      e_wb_reg   = ins[4:0];
      e_wb_data  = res;
      e_chk_data = v && writes;
      e_pc_src   = v && (is_b || (is_cbz && b == 64'd0) || (is_cbnz && b != 64'd0));
      if (is_b)                  e_br = p + (64'($signed(ins[25:0])) << 2);
      else if (is_cbz | is_cbnz) e_br = p + (64'($signed(ins[23:5])) << 2);
      else                       e_br = p + 64'd4;
      e_illegal  = v && !(writes | is_st | is_cbz | is_cbnz | is_b);
      e_store    = v && is_st;
      e_st_idx   = addr[7:3];
      e_st_data  = b;
   endtask

   // Apply one instruction for one cycle; entered and left 1 time unit after a rising edge
   task automatic step(input logic [31:0] ins, input logic [63:0] p, a, b, input logic v);
      instr = ins; pc = p; rs1_data = a; rs2_data = b; valid_in = v;
      model(ins, p, a, b, v);
      #1;
      chk("rs1_addr", 64'(rs1_addr), 64'(ins[9:5]));
      chk("rs2_addr", 64'(rs2_addr), 64'(e_rs2_addr));
      @(posedge clk);
`ifdef EX_STAGE_DATA_MEM_EN
      if (e_store) m_mem[e_st_idx] = e_st_data;
`endif
      #1;
      chk("wb_en", 64'(wb_en), 64'(e_wb_en));
      chk("pc_src", 64'(pc_src), 64'(e_pc_src));
      chk("illegal", 64'(illegal), 64'(e_illegal));
      if (e_valid) begin
         chk("wb_reg", 64'(wb_reg), 64'(e_wb_reg));
         chk("branch_addr", branch_addr, e_br);
      end
      if (e_chk_data) chk("wb_data", wb_data, e_wb_data);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
      case ($urandom_range(0, 11))
         0:  return {11'h458, 5'($urandom), 6'd0, 5'($urandom), rd};
         1:  return {11'h658, 5'($urandom), 6'd0, 5'($urandom), rd};
         2:  return {11'h450, 5'($urandom), 6'd0, 5'($urandom), rd};
         3:  return {11'h550, 5'($urandom), 6'd0, 5'($urandom), rd};
         4:  return {10'b1001000100, 12'($urandom), 5'($urandom), rd};
         5:  return {10'b1101000100, 12'($urandom), 5'($urandom), rd};
         6:  return {11'h7C2, 9'($urandom), 2'b00, 5'($urandom), rd};
         7:  return {11'h7C0, 9'($urandom), 2'b00, 5'($urandom), rd};
         8:  return {8'hB4, 19'($urandom), rd};
         9:  return {8'hB5, 19'($urandom), rd};
         10: return {6'b000101, 26'($urandom)};
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      logic [63:0] d;
      for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
      rst = 1'b1; valid_in = 1'b0; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
      #12;
      chk("reset_wb_en", 64'(wb_en), 64'd0);
      chk("reset_wb_reg", 64'(wb_reg), 64'd0);
      chk("reset_wb_data", wb_data, 64'd0);
      chk("reset_pc_src", 64'(pc_src), 64'd0);
      chk("reset_branch_addr", branch_addr, 64'd0);
      chk("reset_illegal", 64'(illegal), 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Fill every memory word so later loads have known contents
      for (int i = 0; i < 32; i++) begin
         d = {$urandom, $urandom};
         step({11'h7C0, 9'd0, 2'b00, 5'd1, 5'd2}, 64'h1000, 64'(i * 8), d, 1'b1);
      end

      step(32'h8B020023, 64'h0, 64'd5, 64'd7, 1'b1);
      chk("add_rs2_addr", 64'(rs2_addr), 64'd2);
      chk("add_wb_data", wb_data, 64'd12);
      chk("add_wb_reg", 64'(wb_reg), 64'd3);
      step({10'b1101000100, 12'd1, 5'd0, 5'd0}, 64'h4, 64'd0, 64'd0, 1'b1);
      chk("subi_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
      step({11'h458, 5'd2, 6'd0, 5'd1, 5'd31}, 64'h8, 64'd1, 64'd2, 1'b1);
      chk("add_xzr_wb_en", 64'(wb_en), 64'd0);
      step({11'h7C0, 9'd8, 2'b00, 5'd1, 5'd2}, 64'hC, 64'h10, 64'hABCD, 1'b1);
      step({11'h7C2, 9'd8, 2'b00, 5'd1, 5'd4}, 64'h10, 64'h10, 64'd0, 1'b1);
      chk("ldur_wb_reg", 64'(wb_reg), 64'd4);
`ifdef EX_STAGE_DATA_MEM_EN
      chk("ldur_wb_data", wb_data, 64'hABCD);
`else
      chk("ldur_wb_data", wb_data, 64'd0);
`endif
      step({8'hB4, 19'h7FFFE, 5'd5}, 64'h100, 64'd0, 64'd0, 1'b1);
      chk("cbz_taken", 64'(pc_src), 64'd1);
      chk("cbz_target", branch_addr, 64'hF8);
      step({8'hB4, 19'h7FFFE, 5'd5}, 64'h100, 64'd0, 64'd1, 1'b1);
      chk("cbz_not_taken", 64'(pc_src), 64'd0);
      step({8'hB5, 19'h7FFFE, 5'd5}, 64'h100, 64'd0, 64'd1, 1'b1);
      chk("cbnz_taken", 64'(pc_src), 64'd1);
      step({8'hB5, 19'h7FFFE, 5'd5}, 64'h100, 64'd0, 64'd0, 1'b1);
      chk("cbnz_not_taken", 64'(pc_src), 64'd0);
      step({6'b000101, 26'd3}, 64'h40, 64'd0, 64'd0, 1'b1);
      chk("b_target", branch_addr, 64'h4C);
      chk("b_wb_en", 64'(wb_en), 64'd0);
      step(32'h0000_0000, 64'h50, 64'd0, 64'd0, 1'b1);
      chk("illegal_op0", 64'(illegal), 64'd1);

      // Bubbles: suppressed flags and no store
      step({11'h7C0, 9'd0, 2'b00, 5'd1, 5'd2}, 64'h60, 64'h28, 64'h5555, 1'b0);
      step({11'h7C2, 9'd0, 2'b00, 5'd1, 5'd6}, 64'h64, 64'h28, 64'd0, 1'b1);
      step(32'h0000_0000, 64'h68, 64'd0, 64'd0, 1'b0);
      step({6'b000101, 26'd3}, 64'h6C, 64'd0, 64'd0, 1'b0);

      for (int n = 0; n < 400; n++)
         step(rand_instr(), {$urandom, $urandom} & ~64'h3, {$urandom, $urandom},
              ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom},
              $urandom_range(0, 4) != 0);

      // Asynchronous reset in the middle of a cycle
      step(32'h8B020023, 64'h200, 64'd5, 64'd7, 1'b1);
      chk("pre_reset_wb_en", 64'(wb_en), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_wb_en", 64'(wb_en), 64'd0);
      chk("async_wb_reg", 64'(wb_reg), 64'd0);
      chk("async_wb_data", wb_data, 64'd0);
      chk("async_pc_src", 64'(pc_src), 64'd0);
      chk("async_branch_addr", branch_addr, 64'd0);
      chk("async_illegal", 64'(illegal), 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      // Memory survives reset
      for (int i = 0; i < 4; i++)
         step({11'h7C2, 9'd0, 2'b00, 5'd1, 5'd7}, 64'h300, 64'(i * 8), 64'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
